// File: rtl/alu_arb_pkg.sv
// Shared opcodes, branch codes, request struct and arbiter FSM state for alu_arbiter.
package alu_arb_pkg;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_SRL = 5'b10000;
  localparam logic [4:0] OP_SRA = 5'b11000;
  localparam logic [4:0] OP_SLL = 5'b11001;

  localparam logic [2:0] BR_LTZ = 3'b001;
  localparam logic [2:0] BR_EQ  = 3'b100;
  localparam logic [2:0] BR_NE  = 3'b101;
  localparam logic [2:0] BR_LEZ = 3'b110;
  localparam logic [2:0] BR_GTZ = 3'b111;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic [4:0]  conf;
    logic        sign;
    logic [2:0]  branch;
    logic [31:0] in1;
    logic [31:0] in2;
  } alu_req_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester ALU bus: request handshake plus registered response per port.
interface alu_arbiter_if;
  logic        req0_valid, req0_ready, req0_sign, req0_lock;
  logic [4:0]  req0_conf;
  logic [2:0]  req0_branch;
  logic [31:0] req0_in1, req0_in2;
  logic        req1_valid, req1_ready, req1_sign, req1_lock;
  logic [4:0]  req1_conf;
  logic [2:0]  req1_branch;
  logic [31:0] req1_in1, req1_in2;
  logic        rsp0_valid, rsp0_comp, rsp1_valid, rsp1_comp;
  logic [31:0] rsp0_result, rsp1_result;

  modport master (
    output req0_valid, req0_sign, req0_lock, req0_conf, req0_branch, req0_in1, req0_in2,
    output req1_valid, req1_sign, req1_lock, req1_conf, req1_branch, req1_in1, req1_in2,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_comp, rsp0_result, rsp1_valid, rsp1_comp, rsp1_result
  );
  modport slave (
    input  req0_valid, req0_sign, req0_lock, req0_conf, req0_branch, req0_in1, req0_in2,
    input  req1_valid, req1_sign, req1_lock, req1_conf, req1_branch, req1_in1, req1_in2,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_comp, rsp0_result, rsp1_valid, rsp1_comp, rsp1_result
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: result by opcode, branch compare outcome by branch code.
module alu_core
  import alu_arb_pkg::*;
(
  input  alu_req_t    req,
  output logic [31:0] result,
  output logic        comp
);
  logic [4:0] sh;
  logic       lt;

  assign sh = req.in1[4:0];
  assign lt = req.sign ? ($signed(req.in1) < $signed(req.in2)) : (req.in1 < req.in2);

  always_comb begin
    result = '0;
    case (req.conf)
      OP_ADD: result = req.in1 + req.in2;
      OP_OR:  result = req.in1 | req.in2;
      OP_AND: result = req.in1 & req.in2;
      OP_SUB: result = req.in1 - req.in2;
      OP_SLT: result = {31'd0, lt};
      OP_NOR: result = ~(req.in1 | req.in2);
      OP_XOR: result = req.in1 ^ req.in2;
      OP_SRL: result = req.in2 >> sh;
      OP_SRA: result = $unsigned($signed(req.in2) >>> sh);
      OP_SLL: result = req.in2 << sh;
      default: result = '0;
    endcase
  end

  always_comb begin
    comp = 1'b0;
    case (req.branch)
      BR_EQ:  comp = (req.in1 == req.in2);
      BR_NE:  comp = (req.in1 != req.in2);
      BR_LEZ: comp = ($signed(req.in1) <= 32'sd0);
      BR_GTZ: comp = ($signed(req.in1) > 32'sd0);
      BR_LTZ: comp = req.in1[31];
      default: comp = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two-port ALU arbiter with lock (atomic sequence) support and one-cycle result latency.
// Define ALU_ARBITER_RR_EN for round-robin IDLE contention; default is fixed priority to port 0.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);
  localparam bit         LOCKABLE   = (LOCK_MAX > 1);
`ifdef ALU_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t                    state;
  logic [3:0]                cnt;
  logic                      ptr;   // requester favoured on IDLE contention
  logic [NUM_REQ-1:0]        valid, lock, gnt;
  alu_req_t [NUM_REQ-1:0]    req;
  alu_req_t                  req_mux;
  logic                      sel, own;
  logic [31:0]               alu_result;
  logic                      alu_comp;
  logic [NUM_REQ-1:0]        rsp_valid, rsp_comp;
  logic [NUM_REQ-1:0][31:0]  rsp_result;

  assign valid  = {bus.req1_valid, bus.req0_valid};
  assign lock   = {bus.req1_lock, bus.req0_lock};
  assign req[0] = '{conf: bus.req0_conf, sign: bus.req0_sign, branch: bus.req0_branch,
                    in1: bus.req0_in1, in2: bus.req0_in2};
  assign req[1] = '{conf: bus.req1_conf, sign: bus.req1_sign, branch: bus.req1_branch,
                    in1: bus.req1_in1, in2: bus.req1_in2};

  always_comb begin
    gnt = '0;
    if (!reset) begin
      case (state)
        IDLE:    gnt = (valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : valid;
        OWN0:    gnt[0] = valid[0];
        OWN1:    gnt[1] = valid[1];
        default: gnt = '0;
      endcase
    end
  end

  assign sel     = gnt[1];
  assign own     = (state == OWN1);
  assign req_mux = req[sel];

  alu_core u_alu (.req(req_mux), .result(alu_result), .comp(alu_comp));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= 1'b0;
      rsp_valid  <= '0;
      rsp_comp   <= '0;
      rsp_result <= '0;
    end else begin
      rsp_valid <= gnt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          rsp_result[i] <= alu_result;
          rsp_comp[i]   <= alu_comp;
        end
      end
      case (state)
        IDLE: begin
          if (|gnt) begin
            if (lock[sel] && LOCKABLE) begin
              state <= sel ? OWN1 : OWN0;
              cnt   <= 4'd1;
            end else if (lock[sel]) begin
              ptr <= ~sel;  // a lock that cannot be held is an immediate release
            end else begin
              ptr <= RR_EN ? ~sel : 1'b0;
            end
          end
        end
        OWN0, OWN1: begin
          if (!valid[own] || !lock[own] || (cnt + 4'd1 == LOCK_MAX_C)) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= ~own;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.req0_ready  = gnt[0];
  assign bus.req1_ready  = gnt[1];
  assign bus.rsp0_valid  = rsp_valid[0];
  assign bus.rsp1_valid  = rsp_valid[1];
  assign bus.rsp0_result = rsp_result[0];
  assign bus.rsp1_result = rsp_result[1];
  assign bus.rsp0_comp   = rsp_comp[0];
  assign bus.rsp1_comp   = rsp_comp[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors push expected responses, a negedge monitor checks them.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails = 0;

  alu_arbiter_if bus();
  alu_arbiter #(.LOCK_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  logic [31:0] q_res [2][$];
  logic        q_comp[2][$];
  logic [31:0] exp_res [2];
  logic        exp_comp[2];
  logic [31:0] hold_res [2];
  logic        hold_comp[2];

  logic [1:0]        rv, rc, rdy;
  logic [1:0][31:0]  rr;
  assign rv  = {bus.rsp1_valid, bus.rsp0_valid};
  assign rc  = {bus.rsp1_comp, bus.rsp0_comp};
  assign rr  = {bus.rsp1_result, bus.rsp0_result};
  assign rdy = {bus.req1_ready, bus.req0_ready};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops the expected response whenever a port reports one, else checks hold.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rv[p]) begin
        if (q_res[p].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL rsp%0d_unexpected: got result %h with no pending request", p, rr[p]);
        end else begin
          hold_res[p]  = q_res[p].pop_front();
          hold_comp[p] = q_comp[p].pop_front();
          chk($sformatf("rsp%0d_data", p), {31'd0, rc[p], rr[p]}, {31'd0, hold_comp[p], hold_res[p]});
        end
      end else begin
        chk($sformatf("rsp%0d_hold", p), {31'd0, rc[p], rr[p]}, {31'd0, hold_comp[p], hold_res[p]});
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic [4:0] conf, input logic sg,
                         input logic [2:0] br, input logic [31:0] a, input logic [31:0] b,
                         input logic lk, input logic [31:0] er, input logic ec);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_conf = conf; bus.req0_sign = sg; bus.req0_branch = br;
      bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_lock = lk;
    end else begin
      bus.req1_valid = v; bus.req1_conf = conf; bus.req1_sign = sg; bus.req1_branch = br;
      bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_lock = lk;
    end
    exp_res[p]  = er;
    exp_comp[p] = ec;
  endtask

  task automatic idle_both();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Inputs are already driven; check the grant, queue the expected response, advance one cycle.
  task automatic step(input string name, input logic [1:0] exp_gnt);
    #1;
    chk({name, "_ready"}, {62'd0, rdy}, {62'd0, exp_gnt});
    for (int p = 0; p < 2; p++) begin
      if (exp_gnt[p]) begin
        q_res[p].push_back(exp_res[p]);
        q_comp[p].push_back(exp_comp[p]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Shorthand for plain contention operands: port0 1+1=2, port1 2+2=4.
  task automatic both(input logic lk0, input logic lk1);
    set_req(0, 1, 5'b00000, 0, 3'b000, 32'd1, 32'd1, lk0, 32'd2, 0);
    set_req(1, 1, 5'b00000, 0, 3'b000, 32'd2, 32'd2, lk1, 32'd4, 0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      hold_res[p]  = '0;
      hold_comp[p] = 1'b0;
    end
    set_req(0, 1, 5'b00000, 0, 3'b000, 32'd1, 32'd1, 0, 32'd2, 0);
    set_req(1, 1, 5'b00000, 0, 3'b000, 32'd2, 32'd2, 0, 32'd4, 0);
    #2;
    chk("reset_ready", {62'd0, rdy}, 64'd0);
    chk("reset_rsp", {60'd0, rv, rc}, 64'd0);
    chk("reset_result", {rr[1], rr[0]}, 64'd0);
    idle_both();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // single requester ALU vectors
    set_req(0, 1, 5'b00110, 0, 3'b000, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 0);
    step("sub", 2'b01);
    set_req(0, 1, 5'b00111, 1, 3'b001, 32'h8000_0000, 32'd1, 0, 32'd1, 1);
    step("slt_s", 2'b01);
    set_req(0, 1, 5'b00111, 0, 3'b111, 32'h8000_0000, 32'd1, 0, 32'd0, 0);
    step("slt_u", 2'b01);
    set_req(0, 1, 5'b11000, 0, 3'b110, 32'd4, 32'h8000_0000, 0, 32'hF800_0000, 0);
    step("sra", 2'b01);
    set_req(0, 1, 5'b00000, 0, 3'b110, 32'd0, 32'd3, 0, 32'd3, 1);
    step("lez0", 2'b01);
    idle_both();
    set_req(1, 1, 5'b01101, 0, 3'b100, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 32'h5A5A_A5A5, 0);
    step("xor", 2'b10);
    set_req(1, 1, 5'b00000, 0, 3'b101, 32'hFFFF_FFFF, 32'd2, 0, 32'd1, 1);
    step("add_wrap", 2'b10);
    set_req(1, 1, 5'b10000, 0, 3'b000, 32'd4, 32'h8000_0000, 0, 32'h0800_0000, 0);
    step("srl", 2'b10);
    set_req(1, 1, 5'b11001, 0, 3'b111, 32'd33, 32'd3, 0, 32'd6, 1);
    step("sll", 2'b10);
    set_req(1, 1, 5'b01100, 0, 3'b100, 32'd0, 32'd0, 0, 32'hFFFF_FFFF, 1);
    step("nor", 2'b10);
    set_req(1, 1, 5'b00010, 0, 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_F000, 0);
    step("and", 2'b10);
    set_req(1, 1, 5'b00001, 0, 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_FFF0, 0);
    step("or", 2'b10);
    set_req(1, 1, 5'b00011, 0, 3'b010, 32'd5, 32'd5, 0, 32'd0, 0);
    step("bad_op", 2'b10);

    // IDLE contention, no locks
    both(0, 0);
`ifdef ALU_ARBITER_RR_EN
    step("cont0", 2'b01); step("cont1", 2'b10); step("cont2", 2'b01); step("cont3", 2'b10);
`else
    step("cont0", 2'b01); step("cont1", 2'b01); step("cont2", 2'b01); step("cont3", 2'b01);
`endif
    idle_both();
    step("drain0", 2'b00);

    // port1 holds a lock for LOCK_MAX accepts, then port0 gets in
    set_req(1, 1, 5'b00000, 0, 3'b000, 32'd2, 32'd2, 1, 32'd4, 0);
    step("lock1_a", 2'b10);
    both(0, 1);
    step("lock1_b", 2'b10);
    step("lock1_c", 2'b10);
    step("lock1_d", 2'b10);
    step("lock1_rel", 2'b01);
    idle_both();
    step("drain1", 2'b00);

    // owner dropping valid releases; the other port is favoured next
    set_req(0, 1, 5'b00000, 0, 3'b000, 32'd1, 32'd1, 1, 32'd2, 0);
    step("lock0_a", 2'b01);
    set_req(1, 1, 5'b00000, 0, 3'b000, 32'd2, 32'd2, 0, 32'd4, 0);
    bus.req0_valid = 1'b0;
    step("own_drop", 2'b00);
    both(0, 0);
    step("post_drop", 2'b10);
    step("post_drop2", 2'b01);
    idle_both();
    step("drain2", 2'b00);

    // owner accepting with lock=0 releases
    set_req(1, 1, 5'b00000, 0, 3'b000, 32'd2, 32'd2, 1, 32'd4, 0);
    step("lock1_e", 2'b10);
    both(0, 0);
    step("unlock1", 2'b10);
    step("post_unlock", 2'b01);
    idle_both();
    step("drain3", 2'b00);
    step("drain4", 2'b00);

    // reset landing on an accept cycle discards the operation
    set_req(0, 1, 5'b00000, 0, 3'b000, 32'd9, 32'd9, 1, 32'd18, 0);
    #1;
    chk("rst_acc_ready", {62'd0, rdy}, 64'd1);
    reset = 1'b1;
    hold_res[0] = '0; hold_comp[0] = 1'b0;
    hold_res[1] = '0; hold_comp[1] = 1'b0;
    #1;
    chk("rst_ready", {62'd0, rdy}, 64'd0);
    @(posedge clk); #1;
    idle_both();
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_rsp0", {31'd0, bus.rsp0_valid, bus.rsp0_comp, bus.rsp0_result}, 64'd0);
    both(0, 0);
    step("rst_cont", 2'b01);
    idle_both();
    step("drain5", 2'b00);
    step("drain6", 2'b00);

    chk("queues_empty", 64'(q_res[0].size() + q_res[1].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, 4, maximum consecutive accepted locked operations by one owner before forced release (legal 1..15).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  requester N accepted this cycle (accept = valid & ready).
REQ-006 reqN_conf  input  5  ALU operation code.
REQ-007 reqN_sign  input  1  signed compare select for set-less-than.
REQ-008 reqN_branch  input  3  branch compare code.
REQ-009 reqN_in1, reqN_in2  input  32 each  operands.
REQ-010 reqN_lock  input  1  keep grant after this operation (atomic sequence).
REQ-011 rspN_valid  output  1  one-cycle pulse: result for requester N available.
REQ-012 rspN_result  output  32  registered ALU result.
REQ-013 rspN_comp  output  1  registered branch compare outcome.

Function
REQ-014 Ops (conf): 00000 add; 00001 or; 00010 and; 00110 sub; 00111 set-less-than (signed if sign, else unsigned, result in bit 0); 01100 nor; 01101 xor; 10000 in2 logical-right by in1[4:0]; 11000 in2 arithmetic-right by in1[4:0]; 11001 in2 left by in1[4:0]; others 0; all arithmetic modulo 2^32.
REQ-015 Comp (branch): 100 in1==in2; 101 in1!=in2; 110 in1<=0 signed; 111 in1>0 signed; 001 in1<0; others 0.
REQ-016 At most one accept per cycle; ready asserted only to a valid requester; ready is combinational from valid and state.
REQ-017 Latency: accept in cycle T -> rspN_valid=1 with result/comp in T+1 only; non-accepted port's rsp_valid=0 and its result/comp hold last value.
REQ-018 No response backpressure; responses are never dropped except by reset.
REQ-019 FSM states: IDLE, OWN0, OWN1.
REQ-020 IDLE: single valid requester granted; both valid resolved per REQ-030/031.
REQ-021 IDLE -> OWNn when requester n accepted with lock=1 and LOCK_MAX>1; lock counter set to 1.
REQ-022 OWNn: only requester n may be granted; other ready=0; each locked accept increments counter.
REQ-023 OWNn -> IDLE when: accepted with lock=0; or counter reaches LOCK_MAX on a locked accept; or reqn_valid=0 in any cycle.
REQ-024 On release from OWNn, next IDLE arbitration favours the other requester if both valid (both configurations).
REQ-025 Lock counter clears on entry to IDLE; never wraps.

Reset
REQ-026 Reset forces state IDLE, lock counter 0, round-robin pointer favouring requester 0.
REQ-027 Reset forces rspN_valid=0, rspN_result=0, rspN_comp=0 for both ports.
REQ-028 Reset during an accept cycle discards that operation; no response after reset deasserts.
REQ-029 ready outputs are 0 while reset is asserted.

Configuration
REQ-030 Macro ALU_ARBITER_RR_EN defined: IDLE contention resolved round-robin; pointer toggles to the other requester after every IDLE grant.
REQ-031 Macro undefined: IDLE contention always grants requester 0 (fixed priority); REQ-024 still applies.

Structure
REQ-032 Package alu_arb_pkg holds the operation-code constants, branch-code constants, and FSM state typedef.
REQ-033 One sub-module, alu_core: purely combinational ALU implementing REQ-014/015; instantiated once, fed by the granted request mux.

Verification
REQ-034 Only req0 valid, conf=00110, in1=5, in2=7 -> req0_ready same cycle; next cycle rsp0_valid=1, rsp0_result=FFFFFFFE.
REQ-035 Both valid 4 cycles, lock=0, RR_EN defined -> grants 0,1,0,1; undefined -> 0,0,0,0.
REQ-036 req1 lock=1 continuously, req0 valid, LOCK_MAX=4 -> four req1 grants, then req0 granted next.
REQ-037 conf=00111 sign=1, in1=80000000, in2=1 -> result 1; sign=0 -> result 0; conf=11000, in1=4, in2=80000000 -> F8000000; branch=110 with in1=0 -> comp=1.
REQ-038 Reset asserted in the accept cycle of req0 -> no rsp0_valid afterwards, outputs 0, state IDLE, next contention grants req0.
